// File: rtl/intc_pkg.sv
// Shared types and helpers for the prioritising, nesting interrupt controller.
package intc_pkg;

  localparam int unsigned INTC_NUM_SRC = 8;
  localparam int unsigned INTC_ID_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Index of the highest set bit; 0 when the vector is empty (callers gate with |v).
  function automatic logic [INTC_ID_W-1:0] hi_idx(input logic [INTC_NUM_SRC-1:0] v);
    hi_idx = '0;
    for (int unsigned i = 0; i < INTC_NUM_SRC; i++) begin
      if (v[i]) hi_idx = INTC_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with a history flop that exposes the synchronised
// level and a one-cycle rising-edge pulse.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic sync_level,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign rise_c     = sync_q[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising, nesting interrupt controller feeding the CP0 hardware_interrupt
// input: one presented source at a time, nested in-service tracking across eret.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned          NUM_SRC     = INTC_NUM_SRC,
  parameter logic [NUM_SRC-1:0]   LEVEL_MASK  = '0,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NUM_SRC-1:0]   irq_raw,
  input  logic                 mask_wr_en,
  input  logic [NUM_SRC-1:0]   mask_wr_data,
  input  logic                 irq_ack,
  input  logic                 eret,
  output logic [NUM_SRC-1:0]   hardware_interrupt,
  output logic [INTC_ID_W-1:0] irq_id,
  output logic [NUM_SRC-1:0]   pending,
  output logic [NUM_SRC-1:0]   in_service,
  output logic [NUM_SRC-1:0]   irq_mask,
  output logic                 proto_err
);

  state_t                 state, state_next;
  logic [NUM_SRC-1:0]     sync_level, rise;
  logic [NUM_SRC-1:0]     above, elig, ack_vec, eret_vec, hw_next;
  logic [INTC_ID_W-1:0]   hi_is, win_id, id_next;
  logic                   win_valid, ack_ok, eret_ok;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .clr       (clr),
      .raw       (irq_raw[g]),
      .sync_level(sync_level[g]),
      .rise_c    (rise[g])
    );
  end

  // Only sources strictly above the innermost in-service level may compete.
  always_comb begin
    hi_is = hi_idx(INTC_NUM_SRC'(in_service));
    above = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      above[i] = (in_service == '0) || (INTC_ID_W'(i) > hi_is);
    end
    elig      = pending & irq_mask & above;
    win_valid = |elig;
    win_id    = hi_idx(INTC_NUM_SRC'(elig));
  end

  assign ack_ok   = (state == REQ) && irq_ack;
  assign eret_ok  = eret && (in_service != '0);
  assign ack_vec  = ack_ok  ? (NUM_SRC'(1) << irq_id) : '0;
  assign eret_vec = eret_ok ? (NUM_SRC'(1) << hi_is)  : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (win_valid && !eret_ok) state_next = REQ;
      REQ:  if (irq_ack || !win_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Presenting state always carries the current winner, so a newcomer replaces in one cycle.
  always_comb begin
    hw_next = '0;
    id_next = '0;
    if (state_next == REQ) begin
      hw_next = NUM_SRC'(1) << win_id;
      id_next = win_id;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hardware_interrupt <= '0;
      irq_id             <= '0;
      pending            <= '0;
      in_service         <= '0;
      irq_mask           <= '0;
      proto_err          <= 1'b0;
    end else begin
      hardware_interrupt <= hw_next;
      irq_id             <= id_next;
      if (mask_wr_en) irq_mask <= mask_wr_data;
      // A fresh edge wins over the ack clear of the same source.
      pending    <= (LEVEL_MASK & sync_level) | (~LEVEL_MASK & ((pending & ~ack_vec) | rise));
      in_service <= (in_service & ~eret_vec) | ack_vec;
      proto_err  <= proto_err | (irq_ack && (state == IDLE)) | (eret && (in_service == '0));
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table, directed corner
// sequences and randomized traffic compared against a behavioural model.
module tb_interrupt_controller;

  localparam logic [7:0] LVL = 8'h01;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] irq_raw = '0;
  logic       mask_wr_en = 1'b0;
  logic [7:0] mask_wr_data = '0;
  logic       irq_ack = 1'b0;
  logic       eret = 1'b0;
  logic [7:0] hw, pend, isv, msk;
  logic [2:0] id;
  logic       perr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interrupt_controller #(
    .NUM_SRC    (8),
    .LEVEL_MASK (LVL),
    .SYNC_STAGES(2)
  ) dut (
    .clk               (clk),
    .clr               (clr),
    .irq_raw           (irq_raw),
    .mask_wr_en        (mask_wr_en),
    .mask_wr_data      (mask_wr_data),
    .irq_ack           (irq_ack),
    .eret              (eret),
    .hardware_interrupt(hw),
    .irq_id            (id),
    .pending           (pend),
    .in_service        (isv),
    .irq_mask          (msk),
    .proto_err         (perr)
  );

  // Behavioural reference: raw sample history, pending/in-service sets, presented source.
  logic [7:0] m_pend = '0, m_is = '0, m_mask = '0, m_hw = '0;
  logic [2:0] m_id = '0;
  logic       m_err = 1'b0;
  logic [7:0] rq [0:2];

  function automatic int top_bit(input logic [7:0] v);
    top_bit = -1;
    for (int i = 0; i < 8; i++) if (v[i]) top_bit = i;
  endfunction

  always @(posedge clk or posedge clr) begin : model
    logic [7:0] lvl, prv, n_pend, n_is;
    logic       busy, ack_ok, eret_ok;
    int         t, win;
    if (clr) begin
      m_pend <= '0; m_is <= '0; m_mask <= '0; m_hw <= '0; m_id <= '0; m_err <= 1'b0;
      for (int k = 0; k < 3; k++) rq[k] <= '0;
    end else begin
      lvl = rq[1];
      prv = rq[2];
      rq[2] <= rq[1];
      rq[1] <= rq[0];
      rq[0] <= irq_raw;
      busy    = (m_hw != 8'h00);
      ack_ok  = irq_ack && busy;
      eret_ok = eret && (m_is != 8'h00);
      if ((irq_ack && !busy) || (eret && m_is == 8'h00)) m_err <= 1'b1;
      t   = top_bit(m_is);
      win = -1;
      for (int i = 0; i < 8; i++) if (i > t && m_pend[i] && m_mask[i]) win = i;
      for (int i = 0; i < 8; i++) begin
        if (LVL[i]) n_pend[i] = lvl[i];
        else n_pend[i] = (lvl[i] && !prv[i]) || (m_pend[i] && !(ack_ok && i == int'(m_id)));
      end
      n_is = m_is;
      if (eret_ok) n_is[t] = 1'b0;
      if (ack_ok)  n_is[m_id] = 1'b1;
      if (ack_ok || win < 0 || (!busy && eret_ok)) begin
        m_hw <= '0;
        m_id <= '0;
      end else begin
        m_hw <= 8'(1) << win;
        m_id <= 3'(win);
      end
      if (mask_wr_en) m_mask <= mask_wr_data;
      m_pend <= n_pend;
      m_is   <= n_is;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [7:0] e_hw, input logic [2:0] e_id,
                            input logic [7:0] e_pend, input logic [7:0] e_is);
    chk({nm, ".hw"},   64'(hw),   64'(e_hw));
    chk({nm, ".id"},   64'(id),   64'(e_id));
    chk({nm, ".pend"}, 64'(pend), 64'(e_pend));
    chk({nm, ".is"},   64'(isv),  64'(e_is));
  endtask

  // One clock; outputs are compared with the model on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model", 64'({hw, id, pend, isv, msk, perr}), 64'({m_hw, m_id, m_pend, m_is, m_mask, m_err}));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_hw(input logic [7:0] exp, input int budget, input string nm);
    int n;
    n = 0;
    while (hw !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 64'(hw), 64'(exp));
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wr_en = 1'b1; mask_wr_data = m; tick(); mask_wr_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] raw;
    logic       mwe;
    logic [7:0] md;
    logic       ack;
    logic       ert;
    logic [7:0] e_hw;
    logic [2:0] e_id;
    logic [7:0] e_pend;
    logic [7:0] e_is;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h00};
    tbl[1] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h00};
    tbl[2] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h00};
    tbl[3] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 8'h08, 8'h00};
    tbl[4] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 3'd3, 8'h08, 8'h00};
    tbl[5] = '{8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 8'h08};
    tbl[6] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h08};
    tbl[7] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00};
    tbl[8] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h00};

    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    expect_out("reset", 8'h00, 3'd0, 8'h00, 8'h00);
    chk("reset.mask", 64'(msk), 64'(8'h00));
    chk("reset.err", 64'(perr), 64'(1'b0));

    // Single edge source through present / ack / eret.
    for (int r = 0; r < 9; r++) begin
      irq_raw = tbl[r].raw; mask_wr_en = tbl[r].mwe; mask_wr_data = tbl[r].md;
      irq_ack = tbl[r].ack; eret = tbl[r].ert;
      tick();
      expect_out($sformatf("vec%0d", r), tbl[r].e_hw, tbl[r].e_id, tbl[r].e_pend, tbl[r].e_is);
    end
    irq_raw = '0; mask_wr_en = 1'b0; irq_ack = 1'b0; eret = 1'b0;
    ticks(3);

    // Higher-priority newcomer replaces the presented source.
    irq_raw = 8'h04;
    wait_hw(8'h04, 8, "pre.hw2");
    irq_raw = 8'h44;
    wait_hw(8'h40, 8, "pre.hw6");
    chk("pre.id6", 64'(id), 64'(3'd6));
    pulse_ack();
    expect_out("pre.ack", 8'h00, 3'd0, 8'h04, 8'h40);
    ticks(3);
    chk("pre.blocked", 64'(hw), 64'(8'h00));
    pulse_eret();
    chk("pre.eret.is", 64'(isv), 64'(8'h00));
    chk("pre.eret.gap", 64'(hw), 64'(8'h00));
    wait_hw(8'h04, 4, "pre.resume");
    pulse_ack();
    pulse_eret();
    irq_raw = '0;
    ticks(3);

    // Nesting under src 4.
    irq_raw = 8'h10;
    wait_hw(8'h10, 8, "nest.hw4");
    pulse_ack();
    chk("nest.is4", 64'(isv), 64'(8'h10));
    irq_raw = 8'h14;
    ticks(5);
    chk("nest.src2.hw", 64'(hw), 64'(8'h00));
    chk("nest.src2.pend", 64'(pend), 64'(8'h04));
    irq_raw = 8'h94;
    wait_hw(8'h80, 8, "nest.hw7");
    pulse_ack();
    chk("nest.is90", 64'(isv), 64'(8'h90));
    pulse_eret();
    chk("nest.is10", 64'(isv), 64'(8'h10));
    ticks(3);
    chk("nest.still.blocked", 64'(hw), 64'(8'h00));
    pulse_eret();
    chk("nest.is0", 64'(isv), 64'(8'h00));
    wait_hw(8'h04, 4, "nest.resume2");
    pulse_ack();
    pulse_eret();
    irq_raw = '0;
    ticks(3);

    // Level source and masking.
    write_mask(8'h00);
    irq_raw = 8'h01;
    ticks(4);
    chk("lvl.pend", 64'(pend), 64'(8'h01));
    chk("lvl.masked", 64'(hw), 64'(8'h00));
    write_mask(8'h01);
    wait_hw(8'h01, 4, "lvl.present");
    irq_raw = 8'h00;
    wait_hw(8'h00, 5, "lvl.drop");
    chk("lvl.drop.pend", 64'(pend), 64'(8'h00));
    chk("lvl.drop.is", 64'(isv), 64'(8'h00));

    // Protocol errors.
    chk("err.clean", 64'(perr), 64'(1'b0));
    pulse_ack();
    chk("err.ack", 64'(perr), 64'(1'b1));
    expect_out("err.ack", 8'h00, 3'd0, 8'h00, 8'h00);
    pulse_eret();
    chk("err.eret", 64'(perr), 64'(1'b1));
    chk("err.eret.is", 64'(isv), 64'(8'h00));

    // New edge on the ack cycle, then ack+eret together.
    write_mask(8'hFF);
    irq_raw = 8'h20;
    wait_hw(8'h20, 8, "sim.hw5");
    irq_raw = 8'h00;
    tick();
    irq_raw = 8'h20;
    ticks(2);
    pulse_ack();
    expect_out("sim.edgeack", 8'h00, 3'd0, 8'h20, 8'h20);
    irq_raw = 8'hA0;
    wait_hw(8'h80, 8, "sim.hw7");
    irq_ack = 1'b1; eret = 1'b1;
    tick();
    irq_ack = 1'b0; eret = 1'b0;
    chk("sim.ackeret.is", 64'(isv), 64'(8'h80));
    chk("sim.ackeret.hw", 64'(hw), 64'(8'h00));
    pulse_eret();
    wait_hw(8'h20, 4, "sim.resume5");
    pulse_ack();
    pulse_eret();
    irq_raw = '0;
    ticks(3);

    // Asynchronous reset while a request is presented.
    irq_raw = 8'h08;
    wait_hw(8'h08, 8, "ar.hw3");
    #2 clr = 1'b1;
    #1;
    expect_out("ar.async", 8'h00, 3'd0, 8'h00, 8'h00);
    chk("ar.async.err", 64'(perr), 64'(1'b0));
    @(negedge clk);
    clr = 1'b0;
    write_mask(8'hFF);
    tick();
    chk("ar.n1.pend", 64'(pend), 64'(8'h00));
    tick();
    chk("ar.n2.pend", 64'(pend), 64'(8'h08));
    chk("ar.n2.hw", 64'(hw), 64'(8'h00));
    tick();
    chk("ar.n3.hw", 64'(hw), 64'(8'h08));
    chk("ar.n3.id", 64'(id), 64'(3'd3));
    pulse_ack();
    pulse_eret();
    irq_raw = '0;
    ticks(3);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) irq_raw[b] = ~irq_raw[b];
      mask_wr_en   = ($urandom_range(15) == 0);
      mask_wr_data = 8'($urandom);
      irq_ack      = (hw != 8'h00) ? ($urandom_range(2) == 0) : ($urandom_range(39) == 0);
      eret         = ($urandom_range(9) == 0);
      tick();
    end
    irq_raw = '0; mask_wr_en = 1'b0; irq_ack = 1'b0; eret = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Prioritising, nesting interrupt controller that sits between the board interrupt sources and the EX-stage CP0 `hardware_interrupt[7:0]` input.
- Synchronises the raw sources, edge- or level-detects them, and latches pending requests under a software-written enable mask.
- Presents one source at a time as a one-hot request, and tracks in-service sources across CP0 acknowledge and `eret`.

Parameters:
- NUM_SRC, 8, number of sources; bit index = priority, highest index wins.
- LEVEL_MASK, 8'h00, per-source: 1 = level-sensitive, 0 = rising-edge.
- SYNC_STAGES, 2, synchroniser depth per raw input; minimum 2.

Ports:
- clk  input  1  system clock.
- clr  input  1  reset.
- irq_raw  input  NUM_SRC  asynchronous source lines.
- mask_wr_en  input  1  load enable mask this cycle.
- mask_wr_data  input  NUM_SRC  new mask value; 1 = source enabled.
- irq_ack  input  1  one-cycle pulse from CP0 when the presented interrupt is taken.
- eret  input  1  one-cycle pulse when the handler returns.
- hardware_interrupt  output  NUM_SRC  registered one-hot request to CP0; zero when idle.
- irq_id  output  3  index of the presented source; valid while hardware_interrupt != 0.
- pending  output  NUM_SRC  registered pending bits.
- in_service  output  NUM_SRC  registered in-service bits.
- irq_mask  output  NUM_SRC  current enable mask.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock `clk`; reset `clr` is asynchronous, active-high.
- Reset values: all outputs 0, synchroniser/history flops 0, FSM in IDLE. Reset mid-request drops `hardware_interrupt` immediately (asynchronous).
- Synchronise/detect:
  - Each source passes through SYNC_STAGES flops.
  - Edge source: pending set on synchronised 0->1.
  - Level source: pending = synchronised level every cycle; not latched.
- Latency: a raw rise first sampled at posedge N (SYNC_STAGES=2) gives pending set at N+2 and hardware_interrupt at N+3, if eligible and idle.
- Masking: a masked source still latches pending; it is only excluded from arbitration. mask_wr_en takes effect from the next cycle.
- Eligibility: pending & irq_mask, AND index > highest set bit of in_service (any bit if in_service == 0). Winner = highest eligible index.
- FSM, state IDLE:
  - If a winner exists, register hardware_interrupt = one-hot(winner), set irq_id, go to REQ.
- FSM, state REQ:
  - Re-arbitrate every cycle; a higher-priority newcomer replaces the presented source in the same way (one-cycle update).
  - If no source is eligible any more (masked, or level dropped): hardware_interrupt <= 0, go to IDLE.
  - On irq_ack:
    - in_service[irq_id] <= 1.
    - pending[irq_id] <= 0 (edge sources only).
    - hardware_interrupt <= 0, go to IDLE.
    - The acknowledged source is the one presented in that same cycle.
- eret: clears the highest set in_service bit next cycle; lower nested entries resume eligibility.
- Simultaneous events:
  - New edge and ack on the same source in one cycle: pending stays 1.
  - ack and eret in one cycle: eret clears the highest old in_service bit first, then ack sets the new bit.
  - IDLE always waits one cycle after ack/eret before presenting again. No back-to-back present on the ack cycle.
- Errors (proto_err set, sticky until clr; the offending pulse has no other effect):
  - irq_ack while in IDLE.
  - eret while in_service == 0.
- irq_id is 0 in IDLE.

Decomposition:
- intc_pkg:
  - state enum {IDLE, REQ}.
  - INTC_NUM_SRC = 8.
  - INTC_ID_W = 3.
  - function for highest-set-bit index/priority encode.
- Sub-module irq_sync_edge, one per source:
  - SYNC_STAGES synchroniser.
  - History flop.
  - Outputs sync_level and rise pulse.
- Arbitration, pending/in-service registers and FSM stay in the top level.

Test Plan:
- Single edge: mask = 8'hFF, raise irq_raw[3] at cycle 0 -> pending[3] at cycle 2, hardware_interrupt = 8'h08, irq_id = 3 at cycle 3. ack -> in_service = 8'h08, pending = 0, hw = 0 next cycle. eret -> in_service = 0.
- Priority/preempt in REQ: pend src 2, then src 6 arrives while src 2 is presented -> hw switches 8'h04 -> 8'h40. ack -> in_service = 8'h40. After eret, src 2 is re-presented (hw = 8'h04).
- Nesting: in_service = 8'h10 (src 4).
  - Raise src 2 -> not presented.
  - Raise src 7 -> hw = 8'h80; ack -> in_service = 8'h90.
  - eret -> 8'h10, then src 2 still blocked.
  - eret -> 0, then hw = 8'h04.
- Mask/level:
  - LEVEL_MASK = 8'h01, mask = 8'h00, hold src 0 high -> pending[0] = 1, hw = 0.
  - Write mask = 8'h01 -> hw = 8'h01.
  - Drop src 0 before ack -> pending[0] = 0, hw = 0, FSM IDLE.
- Protocol errors and simultaneity:
  - ack in IDLE -> proto_err = 1, nothing else changes.
  - eret with in_service = 0 -> proto_err stays 1.
  - ack and eret same cycle with in_service = 8'h20, presented src 7 -> in_service = 8'h80.
- Async reset mid-REQ: assert clr between clock edges while hw = 8'h08 -> hw, pending, in_service, proto_err all 0 before the next posedge. After release, the first request takes the full N+3 latency.
